// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared bit-serial system bus: one grantee at a time,
// a one-cycle turnaround before it may drive, and a watchdog that reclaims a hung bus.
module serial_bus_arbiter #(
    parameter int NM      = 3,
    parameter int TIMEOUT = 1024,
    localparam int ID_W   = (NM > 1) ? $clog2(NM) : 1,
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NM-1:0]   req,
    input  logic [NM-1:0]   done,
    input  logic            hold,
    output logic [NM-1:0]   grant,
    output logic [ID_W-1:0] grant_id,
    output logic            BusAvailable,
    output logic            bus_busy,
    output logic            timeout_err,
    output logic [1:0]      state_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] wd_cnt;
    logic             pick_vld;
    logic [ID_W-1:0]  pick_id;
    logic [NM-1:0]    pick_oh;
    logic             wd_inc, wd_expire, busy_exit;

    // Scan from ptr+1 upward; iterating downward lets the nearest requester win.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        pick_oh  = '0;
        for (int i = NM; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NM]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'((int'(ptr) + i) % NM);
                pick_oh  = '0;
                pick_oh[(int'(ptr) + i) % NM] = 1'b1;
            end
        end
    end

    assign wd_inc    = (TIMEOUT != 0) && !hold;
    assign wd_expire = (state == S_BUSY) && wd_inc && (wd_cnt == WD_LAST);
    assign busy_exit = done[grant_id] || !req[grant_id] || wd_expire;
    assign state_out = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (pick_vld) state_nxt = S_GRANT;
            S_GRANT:   state_nxt = S_BUSY;
            S_BUSY:    if (busy_exit) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant        <= '0;
            grant_id     <= '0;
            ptr          <= ID_W'(NM - 1);
            wd_cnt       <= '0;
            BusAvailable <= 1'b0;
            bus_busy     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            BusAvailable <= (state_nxt == S_BUSY);
            bus_busy     <= (state_nxt == S_GRANT) || (state_nxt == S_BUSY);
            // A done landing on the expiry cycle counts as a clean finish.
            timeout_err  <= wd_expire && !done[grant_id];
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant    <= pick_oh;
                        grant_id <= pick_id;
                    end else begin
                        grant <= '0;
                    end
                end
                S_GRANT: wd_cnt <= '0;
                S_BUSY: begin
                    if (busy_exit)   grant  <= '0;
                    else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;
                end
                S_RELEASE: begin
                    grant <= '0;
                    ptr   <= grant_id;
                end
                default: grant <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter (NM=3, TIMEOUT=8): handshake timing,
// rotation order, watchdog with and without hold, abandon, and async reset.
module tb_serial_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = '0;
    logic [2:0] done = '0;
    logic       hold = 1'b0;
    logic [2:0] grant;
    logic [1:0] grant_id;
    logic       BusAvailable;
    logic       bus_busy;
    logic       timeout_err;
    logic [1:0] state_out;

    int n_pass  = 0;
    int n_total = 0;

    serial_bus_arbiter #(.NM(3), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .hold        (hold),
        .grant       (grant),
        .grant_id    (grant_id),
        .BusAvailable(BusAvailable),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL bench_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [2:0] exp_g;
        int id;

        // Reset values
        #1 reset = 1'b0;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busavail", BusAvailable, 0);
        chk("rst_bus_busy", bus_busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_state", state_out, 0);
        tick(); tick();
        reset = 1'b1;
        req = 3'b001;

        // Single transaction: grant after edge 1, BusAvailable after edge 2, done at edge 5
        tick();
        chk("t1_grant", grant, 3'b001);
        chk("t1_state_grant", state_out, 1);
        chk("t1_ba_turnaround", BusAvailable, 0);
        chk("t1_busy_grant", bus_busy, 1);
        tick();
        chk("t1_ba", BusAvailable, 1);
        chk("t1_state_busy", state_out, 2);
        tick(); tick();
        done = 3'b001;
        tick();
        chk("t1_rel_grant", grant, 0);
        chk("t1_rel_ba", BusAvailable, 0);
        chk("t1_rel_busy", bus_busy, 0);
        chk("t1_rel_state", state_out, 3);
        done = 3'b000;
        req = 3'b000;
        tick();
        chk("t1_idle_state", state_out, 0);

        // Fresh reset so master 0 leads the rotation
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            id = k % 3;
            exp_g = 3'b001 << id;
            tick();
            chk("rr_grant", grant, exp_g);
            chk("rr_grant_id", grant_id, id);
            tick();
            chk("rr_ba", BusAvailable, 1);
            tick();
            done = exp_g;
            tick();
            chk("rr_gap1_grant", grant, 0);
            chk("rr_gap1_state", state_out, 3);
            done = 3'b000;
            tick();
            chk("rr_gap2_grant", grant, 0);
            chk("rr_gap2_state", state_out, 0);
        end

        // Watchdog expiry on master 1
        req = 3'b010;
        tick();
        chk("wd_grant", grant, 3'b010);
        req = 3'b110;
        tick();
        chk("wd_state_busy", state_out, 2);
        repeat (7) tick();
        chk("wd_before_state", state_out, 2);
        chk("wd_before_err", timeout_err, 0);
        tick();
        chk("wd_rel_state", state_out, 3);
        chk("wd_err_pulse", timeout_err, 1);
        chk("wd_rel_grant", grant, 0);
        tick();
        chk("wd_err_clear", timeout_err, 0);
        chk("wd_idle_state", state_out, 0);
        tick();
        chk("wd_next_grant", grant, 3'b100);

        // Hold freezes the watchdog
        tick();
        hold = 1'b1;
        repeat (20) tick();
        chk("hold_state", state_out, 2);
        chk("hold_err", timeout_err, 0);
        hold = 1'b0;
        repeat (4) tick();
        done = 3'b100;
        tick();
        chk("hold_rel_state", state_out, 3);
        chk("hold_rel_err", timeout_err, 0);
        done = 3'b000;
        req = 3'b100;
        tick();
        chk("hold_idle_state", state_out, 0);

        // Master 2 abandons; foreign done ignored
        tick();
        chk("ab_grant", grant, 3'b100);
        tick(); tick();
        done = 3'b001;
        tick();
        chk("ab_foreign_done_state", state_out, 2);
        chk("ab_foreign_done_grant", grant, 3'b100);
        done = 3'b000;
        req = 3'b000;
        tick();
        chk("ab_rel_state", state_out, 3);
        chk("ab_rel_err", timeout_err, 0);
        req = 3'b010;
        tick();

        // done during GRANT ignored; leaves ptr at 1
        tick();
        chk("dg_grant", grant, 3'b010);
        done = 3'b010;
        tick();
        chk("dg_state_busy", state_out, 2);
        done = 3'b000;
        tick();
        done = 3'b010;
        tick();
        chk("dg_rel_state", state_out, 3);
        done = 3'b000;
        req = 3'b001;
        tick();
        tick();
        chk("ar_grant0", grant, 3'b001);

        // Async reset mid-BUSY, then ptr must restart at NM-1
        tick(); tick();
        #3 reset = 1'b0;
        #1;
        chk("ar_grant", grant, 0);
        chk("ar_ba", BusAvailable, 0);
        chk("ar_bus_busy", bus_busy, 0);
        chk("ar_state", state_out, 0);
        req = 3'b110;
        tick();
        reset = 1'b1;
        tick();
        chk("ar_post_grant", grant, 3'b010);
        chk("ar_post_grant_id", grant_id, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
